// File: rtl/avalon_timer_multi.sv
// Multi-channel Avalon-MM interval timer: per-channel period, prescaler,
// snapshot, interrupt and single-cycle tick.
module avalon_timer_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999,
  localparam int ADDR_W      = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;
  localparam logic [2:0] REG_SNAP     = 3'd4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

  ch_state_t          state_r     [NUM_CH];
  ch_state_t          state_s     [NUM_CH];
  logic [CNT_W-1:0]   period_r    [NUM_CH];
  logic [CNT_W-1:0]   period_s    [NUM_CH];
  logic [CNT_W-1:0]   counter_r   [NUM_CH];
  logic [CNT_W-1:0]   counter_s   [NUM_CH];
  logic [CNT_W-1:0]   snap_r      [NUM_CH];
  logic [CNT_W-1:0]   snap_s      [NUM_CH];
  logic [PRE_W-1:0]   prescale_r  [NUM_CH];
  logic [PRE_W-1:0]   prescale_s  [NUM_CH];
  logic [PRE_W-1:0]   presc_cnt_r [NUM_CH];
  logic [PRE_W-1:0]   presc_cnt_s [NUM_CH];
  logic [31:0]        ch_rd_s     [NUM_CH];

  logic [NUM_CH-1:0]  timeout_r, timeout_s, ito_r, ito_s, cont_r, cont_s;
  logic [NUM_CH-1:0]  tick_r, tick_s, irq_vec_r, irq_vec_s;
  logic [NUM_CH-1:0]  ch_hit_s, wr_status_s, wr_ctrl_s, wr_period_s, wr_pre_s, wr_snap_s;
  logic [NUM_CH-1:0]  start_s, stop_s, dec_en_s, expire_s;
  logic               wr_s;
  logic               irq_r;
  logic [ADDR_W-1:0]  ch_sel_s;
  logic [2:0]         reg_sel_s;
  logic [31:0]        rd_s;
  logic [31:0]        readdata_r;

  // Address decode into per-channel register strobes.
  always_comb begin
    wr_s      = chipselect && !write_n;
    ch_sel_s  = address >> 3'd3;
    reg_sel_s = address[2:0];
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit_s[i]    = (ch_sel_s == ADDR_W'(i));
      wr_status_s[i] = wr_s && ch_hit_s[i] && (reg_sel_s == REG_STATUS);
      wr_ctrl_s[i]   = wr_s && ch_hit_s[i] && (reg_sel_s == REG_CONTROL);
      wr_period_s[i] = wr_s && ch_hit_s[i] && (reg_sel_s == REG_PERIOD);
      wr_pre_s[i]    = wr_s && ch_hit_s[i] && (reg_sel_s == REG_PRESCALE);
      wr_snap_s[i]   = wr_s && ch_hit_s[i] && (reg_sel_s == REG_SNAP);
      start_s[i]     = wr_ctrl_s[i] && writedata[2];
      stop_s[i]      = wr_ctrl_s[i] && writedata[3];
    end
  end

  // Per-channel next state: prescaler, counter, run FSM and status bits.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_s[i]     = state_r[i];
      period_s[i]    = period_r[i];
      counter_s[i]   = counter_r[i];
      snap_s[i]      = snap_r[i];
      prescale_s[i]  = prescale_r[i];
      presc_cnt_s[i] = presc_cnt_r[i];
      timeout_s[i]   = timeout_r[i];
      ito_s[i]       = ito_r[i];
      cont_s[i]      = cont_r[i];
      dec_en_s[i]    = (state_r[i] == RUN) && (presc_cnt_r[i] == {PRE_W{1'b0}});
      // A PERIOD write overrides any count step in the same cycle.
      expire_s[i]    = dec_en_s[i] && (counter_r[i] == {CNT_W{1'b0}}) && !wr_period_s[i];
      tick_s[i]      = expire_s[i];

      if (wr_period_s[i]) begin
        period_s[i]    = writedata[CNT_W-1:0];
        counter_s[i]   = writedata[CNT_W-1:0];
        presc_cnt_s[i] = prescale_r[i];
      end else if (dec_en_s[i]) begin
        counter_s[i]   = expire_s[i] ? period_r[i] : counter_r[i] - CNT_W'(1);
        presc_cnt_s[i] = prescale_r[i];
      end else if (state_r[i] == RUN) begin
        presc_cnt_s[i] = presc_cnt_r[i] - PRE_W'(1);
      end else begin
        presc_cnt_s[i] = presc_cnt_r[i];
      end

      if (wr_pre_s[i]) begin
        prescale_s[i] = writedata[PRE_W-1:0];
      end else begin
        prescale_s[i] = prescale_r[i];
      end

      if (wr_snap_s[i]) begin
        snap_s[i] = counter_r[i];
      end else begin
        snap_s[i] = snap_r[i];
      end

      if (wr_ctrl_s[i]) begin
        ito_s[i]  = writedata[0];
        cont_s[i] = writedata[1];
      end else begin
        ito_s[i]  = ito_r[i];
        cont_s[i] = cont_r[i];
      end

      // Timeout beats a concurrent status clear so no event is dropped.
      if (expire_s[i]) begin
        timeout_s[i] = 1'b1;
      end else if (wr_status_s[i]) begin
        timeout_s[i] = 1'b0;
      end else begin
        timeout_s[i] = timeout_r[i];
      end

      case (state_r[i])
        IDLE: state_s[i] = start_s[i] ? RUN : IDLE;
        RUN: begin
          if (start_s[i]) begin
            state_s[i] = RUN;
          end else if (stop_s[i] || wr_period_s[i] || (expire_s[i] && !cont_r[i])) begin
            state_s[i] = IDLE;
          end else begin
            state_s[i] = RUN;
          end
        end
        default: state_s[i] = IDLE;
      endcase
    end
    irq_vec_s = timeout_s & ito_s;
  end

  // Read mux; channels outside NUM_CH and reserved offsets yield zero.
  always_comb begin
    rd_s = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rd_s[i] = 32'd0;
      case (reg_sel_s)
        REG_STATUS:   ch_rd_s[i][1:0]       = {state_r[i] == RUN, timeout_r[i]};
        REG_CONTROL:  ch_rd_s[i][1:0]       = {cont_r[i], ito_r[i]};
        REG_PERIOD:   ch_rd_s[i][CNT_W-1:0] = period_r[i];
        REG_PRESCALE: ch_rd_s[i][PRE_W-1:0] = prescale_r[i];
        REG_SNAP:     ch_rd_s[i][CNT_W-1:0] = snap_r[i];
        default:      ch_rd_s[i]            = 32'd0;
      endcase
      rd_s = rd_s | (ch_hit_s[i] ? ch_rd_s[i] : 32'd0);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]     <= IDLE;
        period_r[i]    <= CNT_W'(RESET_PERIOD);
        counter_r[i]   <= CNT_W'(RESET_PERIOD);
        snap_r[i]      <= {CNT_W{1'b0}};
        prescale_r[i]  <= {PRE_W{1'b0}};
        presc_cnt_r[i] <= {PRE_W{1'b0}};
      end
      timeout_r  <= {NUM_CH{1'b0}};
      ito_r      <= {NUM_CH{1'b0}};
      cont_r     <= {NUM_CH{1'b0}};
      tick_r     <= {NUM_CH{1'b0}};
      irq_vec_r  <= {NUM_CH{1'b0}};
      irq_r      <= 1'b0;
      readdata_r <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]     <= state_s[i];
        period_r[i]    <= period_s[i];
        counter_r[i]   <= counter_s[i];
        snap_r[i]      <= snap_s[i];
        prescale_r[i]  <= prescale_s[i];
        presc_cnt_r[i] <= presc_cnt_s[i];
      end
      timeout_r  <= timeout_s;
      ito_r      <= ito_s;
      cont_r     <= cont_s;
      tick_r     <= tick_s;
      irq_vec_r  <= irq_vec_s;
      irq_r      <= |irq_vec_s;
      readdata_r <= rd_s;
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;
  assign irq_vec  = irq_vec_r;
  assign tick     = tick_r;

endmodule

// File: tb/tb_avalon_timer_multi.sv
// Self-checking bench for avalon_timer_multi; five channels so that an
// out-of-range channel index is addressable.
module tb_avalon_timer_multi;

  localparam int NCH = 5;
  localparam int AW  = $clog2(NCH) + 3;

  logic           clk;
  logic           reset_n;
  logic           chipselect;
  logic [AW-1:0]  address;
  logic           write_n;
  logic [31:0]    writedata;
  logic [31:0]    readdata;
  logic           irq;
  logic [NCH-1:0] irq_vec;
  logic [NCH-1:0] tick;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [31:0] exp_q[$];

  avalon_timer_multi #(.NUM_CH(NCH), .CNT_W(32), .PRE_W(8), .RESET_PERIOD(49999)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end at a falling edge.
  task automatic wr(input int ch, input int r, input logic [31:0] data);
    chipselect = 1'b1; write_n = 1'b0;
    address = AW'(ch * 8 + r); writedata = data;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input int ch, input int r, input logic [31:0] expv, input string name);
    logic [31:0] e;
    exp_q.push_back(expv);
    chipselect = 1'b1; write_n = 1'b1; address = AW'(ch * 8 + r);
    @(negedge clk);
    chipselect = 1'b0;
    e = exp_q.pop_front();
    check_cnt++;
    if (readdata !== e) $display("FAIL %s: readdata=%0d expected=%0d", name, readdata, e);
    else pass_cnt++;
  endtask

  task automatic wait_tick(input int ch, input int maxc, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tick[ch] && k <= maxc);
  endtask

  task automatic wait_irq(input int maxc, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!irq && k <= maxc);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = 32'd0;
    #1 reset_n = 1'b0;
    #2;
    check_cnt++;
    if ({readdata, irq, irq_vec, tick} !== {32'd0, 1'b0, 5'd0, 5'd0})
      $display("FAIL reset_outputs: rd=%0d irq=%b vec=%b tick=%b expected all zero", readdata, irq, irq_vec, tick);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(0, 2, 32'd49999, "reset_period");
    rd(0, 0, 32'd0, "reset_status");
    rd(0, 3, 32'd0, "reset_prescale");
    rd(0, 1, 32'd0, "reset_control");
    rd(0, 4, 32'd0, "reset_snap");
    check_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: irq=%b expected=0", irq);
    else pass_cnt++;
  endtask

  task automatic test_continuous();
    int k;
    wr(1, 3, 32'd0);
    wr(1, 2, 32'd9);
    wr(1, 1, 32'h7);
    wait_tick(1, 40, k);
    check_cnt++;
    if (k !== 10) $display("FAIL cont_first_tick: cycles=%0d expected=10", k);
    else pass_cnt++;
    check_cnt++;
    if ({irq, irq_vec[1]} !== 2'b11) $display("FAIL cont_irq: irq=%b vec1=%b expected=11", irq, irq_vec[1]);
    else pass_cnt++;
    wait_tick(1, 40, k);
    check_cnt++;
    if (k !== 10) $display("FAIL cont_second_tick: cycles=%0d expected=10", k);
    else pass_cnt++;
    wr(1, 0, 32'd0);
    check_cnt++;
    if ({irq, irq_vec[1]} !== 2'b00) $display("FAIL cont_irq_clear: irq=%b vec1=%b expected=00", irq, irq_vec[1]);
    else pass_cnt++;
    // Clear was presented 10 clk before the next timeout becomes visible.
    wait_irq(40, k);
    check_cnt++;
    if (k !== 9) $display("FAIL cont_irq_reassert: cycles=%0d expected=9", k);
    else pass_cnt++;
    wr(1, 1, 32'h8);
    wr(1, 0, 32'd0);
    check_cnt++;
    if (irq !== 1'b0) $display("FAIL cont_stop_irq: irq=%b expected=0", irq);
    else pass_cnt++;
  endtask

  task automatic test_oneshot();
    int k;
    int n;
    wr(2, 3, 32'd4);
    wr(2, 2, 32'd3);
    wr(2, 1, 32'h5);
    wait_tick(2, 60, k);
    check_cnt++;
    if (k !== 20) $display("FAIL oneshot_tick: cycles=%0d expected=20", k);
    else pass_cnt++;
    rd(2, 0, 32'h1, "oneshot_status");
    wr(2, 4, 32'd0);
    rd(2, 4, 32'd3, "oneshot_snap");
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tick[2]) n++;
    end
    check_cnt++;
    if (n !== 0) $display("FAIL oneshot_repeat: ticks=%0d expected=0", n);
    else pass_cnt++;
  endtask

  task automatic test_snapshot();
    wr(0, 3, 32'd0);
    wr(0, 2, 32'd100);
    wr(0, 1, 32'h6);
    repeat (7) @(negedge clk);
    wr(0, 4, 32'd0);
    rd(0, 4, 32'd93, "snap_value");
    rd(0, 0, 32'h2, "snap_running");
    wr(0, 2, 32'd5);
    rd(0, 0, 32'h0, "period_wr_idle");
    wr(0, 4, 32'd0);
    rd(0, 4, 32'd5, "period_wr_counter");
  endtask

  task automatic test_simultaneous();
    wr(3, 3, 32'd0);
    wr(3, 2, 32'd4);
    wr(3, 1, 32'h7);
    repeat (4) @(negedge clk);
    wr(3, 0, 32'd0);
    check_cnt++;
    if (irq_vec[3] !== 1'b1) $display("FAIL clear_vs_timeout_irq: vec3=%b expected=1", irq_vec[3]);
    else pass_cnt++;
    rd(3, 0, 32'h3, "clear_vs_timeout");
    wr(3, 1, 32'h8);
    wr(3, 1, 32'hC);
    rd(3, 0, 32'h3, "start_beats_stop");
  endtask

  task automatic test_reset_midrun();
    wr(0, 1, 32'h7);
    wr(1, 1, 32'h7);
    wr(2, 1, 32'h7);
    wr(4, 1, 32'h7);
    rd(0, 2, 32'd5, "midrun_period");
    repeat (10) @(negedge clk);
    check_cnt++;
    if ({irq, readdata} !== {1'b1, 32'd5}) $display("FAIL midrun_pre: irq=%b rd=%0d expected irq=1 rd=5", irq, readdata);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({readdata, irq, irq_vec, tick} !== {32'd0, 1'b0, 5'd0, 5'd0})
      $display("FAIL midrun_async_reset: rd=%0d irq=%b vec=%b tick=%b expected all zero", readdata, irq, irq_vec, tick);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    rd(0, 0, 32'h0, "midrun_status");
    rd(0, 2, 32'd49999, "midrun_period_reset");
    rd(1, 1, 32'h0, "midrun_control");
  endtask

  task automatic test_invalid_channel();
    wr(5, 2, 32'd123);
    wr(5, 1, 32'h7);
    wr(0, 5, 32'hFFFF_FFFF);
    rd(5, 2, 32'd0, "badch_period");
    rd(5, 0, 32'd0, "badch_status");
    rd(0, 5, 32'd0, "reserved_offset");
    rd(0, 2, 32'd49999, "badch_no_alias");
    repeat (20) @(negedge clk);
    check_cnt++;
    if ({irq, tick} !== {1'b0, 5'd0}) $display("FAIL badch_quiet: irq=%b tick=%b expected 0", irq, tick);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_snapshot();
    test_simultaneous();
    test_reset_midrun();
    test_invalid_channel();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
